// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types, constants and sector lookup for the SVM PWM sequencer
package svm_pkg;

  // Sequencer state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } svm_state_t;

  // Phase indices
  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;

  localparam int T_TAST_DEFAULT = 20000;
  localparam int DEAD_DEFAULT   = 100;

  // Phase that switches first (threshold a), middle, and last (threshold c)
  typedef struct packed {
    logic [1:0] first;
    logic [1:0] mid;
    logic [1:0] last;
  } svm_order_t;

  function automatic svm_order_t svm_sector_order(input logic [2:0] sector);
    svm_order_t order;
    case (sector)
      3'd1:    order = {PH_A, PH_B, PH_C};
      3'd2:    order = {PH_B, PH_A, PH_C};
      3'd3:    order = {PH_B, PH_C, PH_A};
      3'd4:    order = {PH_C, PH_B, PH_A};
      3'd5:    order = {PH_C, PH_A, PH_B};
      3'd6:    order = {PH_A, PH_C, PH_B};
      // Invalid sectors are masked by FAULT; any order will do
      default: order = {PH_A, PH_B, PH_C};
    endcase
    return order;
  endfunction

endpackage

// File: rtl/svm_dead_time.sv
// rtl/svm_dead_time.sv - dead-time protected gate pair for one half-bridge phase
module svm_dead_time
  import svm_pkg::*;
#(
  parameter int DEAD = DEAD_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_off,
  input  logic i_des,
  output logic o_hi,
  output logic o_lo
);

  localparam int CW = (DEAD < 1) ? 1 : $clog2(DEAD + 1);

  logic          r_target;
  logic [CW-1:0] r_cnt;
  logic          r_hi;
  logic          r_lo;

  // Any change of target drops both gates; the new side is driven only after the dead count expires
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_target <= 1'b0;
      r_cnt    <= CW'(DEAD);
      r_hi     <= 1'b0;
      r_lo     <= 1'b0;
    end else if (i_off) begin
      // Off is immediate; a later enable still waits a full dead time before LO
      r_target <= 1'b0;
      r_cnt    <= CW'(DEAD);
      r_hi     <= 1'b0;
      r_lo     <= 1'b0;
    end else if (i_des != r_target) begin
      r_target <= i_des;
      r_cnt    <= CW'(DEAD);
      r_hi     <= 1'b0;
      r_lo     <= 1'b0;
    end else if (r_cnt > CW'(1)) begin
      r_cnt <= r_cnt - 1'b1;
    end else begin
      r_cnt <= '0;
      r_hi  <= r_target;
      r_lo  <= ~r_target;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/svm_pwm_sequencer.sv
// rtl/svm_pwm_sequencer.sv - space-vector PWM period sequencer with 7-segment pattern and dead time
module svm_pwm_sequencer
  import svm_pkg::*;
#(
  parameter int T_TAST = T_TAST_DEFAULT,
  parameter int DEAD   = DEAD_DEFAULT,
  parameter int TW     = 15
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          ENABLE,
  input  logic [TW-1:0] T_1,
  input  logic [TW-1:0] T_2,
  input  logic [2:0]    SECTOR,
  output logic          SAMPLE,
  output logic [2:0]    GATE_HI,
  output logic [2:0]    GATE_LO,
  output logic          SAT,
  output logic          FAULT
);

  localparam logic [TW-1:0] L_TAST = TW'(T_TAST);
  localparam logic [TW-1:0] L_HALF = TW'(T_TAST / 2);
  localparam logic [TW-1:0] L_LAST = TW'(T_TAST - 1);

  svm_state_t    r_state;
  logic [TW-1:0] r_cnt;
  logic          r_sample;
  logic [TW-1:0] r_t1;
  logic [TW-1:0] r_t2;
  logic [2:0]    r_sector;
  logic          r_sat;
  logic          r_fault;
  logic [TW-1:0] r_a;
  logic [TW-1:0] r_b1;
  logic [TW-1:0] r_b2;
  logic [TW-1:0] r_c;

  logic [TW:0]   w_sum;
  logic [TW-1:0] w_t1;
  logic [TW-1:0] w_t2;
  logic          w_sat;
  logic          w_sector_bad;
  logic [TW-1:0] w_t0;
  logic [TW-1:0] w_a;
  logic [TW-1:0] w_mid;
  logic [TW-1:0] w_pos;
  logic [TW-1:0] w_thr;
  svm_order_t    w_order;
  logic [2:0]    w_des;
  logic          w_off;

  // Clamp the incoming dwell times so the active vectors never exceed one period
  always_comb begin
    w_sum = {1'b0, T_1} + {1'b0, T_2};
    w_t1  = T_1;
    w_t2  = T_2;
    w_sat = 1'b0;
    if (T_1 >= L_TAST) begin
      w_t1  = L_TAST;
      w_t2  = '0;
      w_sat = 1'b1;
    end else if (w_sum > {1'b0, L_TAST}) begin
      w_t2  = L_TAST - T_1;
      w_sat = 1'b1;
    end
  end

  assign w_sector_bad = (SECTOR == 3'd0) || (SECTOR == 3'd7);

  // Period sequencer: IDLE -> one PRIME period -> RUN, latching inputs on the last count
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sample <= 1'b0;
      r_t1     <= '0;
      r_t2     <= '0;
      r_sector <= '0;
      r_sat    <= 1'b0;
      r_fault  <= 1'b0;
    end else if (!ENABLE) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sample <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state  <= ST_PRIME;
          r_cnt    <= '0;
          r_sample <= 1'b1;
        end
        default: begin
          if (r_cnt == L_LAST) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_sample <= 1'b1;
            r_t1     <= w_t1;
            r_t2     <= w_t2;
            r_sector <= SECTOR;
            r_sat    <= w_sat;
            r_fault  <= w_sector_bad;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign w_t0 = L_TAST - r_t1 - r_t2;
  assign w_a  = w_t0 >> 2;

  // Switching thresholds, one cycle behind the shadow registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_a  <= '0;
      r_b1 <= '0;
      r_b2 <= '0;
      r_c  <= '0;
    end else begin
      r_a  <= w_a;
      r_b1 <= w_a + (r_t1 >> 1);
      r_b2 <= w_a + (r_t2 >> 1);
      r_c  <= w_a + (r_t1 >> 1) + (r_t2 >> 1);
    end
  end

  // Center-aligned pattern: fold the counter and compare each phase against its threshold
  always_comb begin
    w_order = svm_sector_order(r_sector);
    w_mid   = r_sector[0] ? r_b1 : r_b2;
    w_pos   = (r_cnt < L_HALF) ? r_cnt : (L_LAST - r_cnt);
    w_des   = '0;
    w_thr   = '0;
    for (int ph = 0; ph < 3; ph++) begin
      w_thr = '0;
      if (w_order.first == 2'(ph)) w_thr = r_a;
      if (w_order.mid   == 2'(ph)) w_thr = w_mid;
      if (w_order.last  == 2'(ph)) w_thr = r_c;
      w_des[ph] = (r_state == ST_RUN) && !r_fault && (w_pos >= w_thr);
    end
  end

  assign w_off = !ENABLE || (r_state == ST_IDLE);

  for (genvar g = 0; g < 3; g++) begin : g_phase
    svm_dead_time #(
      .DEAD(DEAD)
    ) u_dead_time (
      .i_clk  (CLK),
      .i_rst_n(RESET_N),
      .i_off  (w_off),
      .i_des  (w_des[g]),
      .o_hi   (GATE_HI[g]),
      .o_lo   (GATE_LO[g])
    );
  end

  assign SAMPLE = r_sample;
  assign SAT    = r_sat;
  assign FAULT  = r_fault;

endmodule

// File: tb/tb_svm_pwm_sequencer.sv
// tb/tb_svm_pwm_sequencer.sv - directed self-checking bench for svm_pwm_sequencer
module tb_svm_pwm_sequencer;

  localparam int T  = 2000;
  localparam int D  = 10;
  localparam int TW = 15;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [TW-1:0] t_1;
  logic [TW-1:0] t_2;
  logic [2:0]    sector;
  logic          sample;
  logic [2:0]    gate_hi;
  logic [2:0]    gate_lo;
  logic          sat;
  logic          fault;

  int errors  = 0;
  int checks  = 0;
  int overlap = 0;
  int hi_cnt[3];
  int lo_cnt[3];
  logic [2:0] mid_hi;
  logic [2:0] mid_lo;
  logic       mid_sat;
  logic       mid_fault;
  int waited;

  svm_pwm_sequencer #(
    .T_TAST(T),
    .DEAD  (D),
    .TW    (TW)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .ENABLE (enable),
    .T_1    (t_1),
    .T_2    (t_2),
    .SECTOR (sector),
    .SAMPLE (sample),
    .GATE_HI(gate_hi),
    .GATE_LO(gate_lo),
    .SAT    (sat),
    .FAULT  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((gate_hi & gate_lo) != 3'b000) overlap++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for SAMPLE, sampled on the falling edge
  task automatic wait_sample(output int n);
    n = 0;
    while (sample !== 1'b1 && n < 3 * T) begin
      @(negedge clk);
      n++;
    end
    check("sample_seen", int'(sample), 1);
  endtask

  // Count gate-on cycles over one period starting at the SAMPLE cycle
  task automatic measure();
    for (int ph = 0; ph < 3; ph++) begin
      hi_cnt[ph] = 0;
      lo_cnt[ph] = 0;
    end
    for (int i = 0; i < T; i++) begin
      for (int ph = 0; ph < 3; ph++) begin
        hi_cnt[ph] += int'(gate_hi[ph]);
        lo_cnt[ph] += int'(gate_lo[ph]);
      end
      if (i == T / 2) begin
        mid_hi    = gate_hi;
        mid_lo    = gate_lo;
        mid_sat   = sat;
        mid_fault = fault;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    t_1    = 15'd400;
    t_2    = 15'd200;
    sector = 3'd1;
    repeat (3) @(negedge clk);

    check("reset_sample", int'(sample), 0);
    check("reset_hi", int'(gate_hi), 0);
    check("reset_lo", int'(gate_lo), 0);
    check("reset_sat", int'(sat), 0);
    check("reset_fault", int'(fault), 0);

    rst_n  = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    wait_sample(waited);
    check("first_sample_latency", waited, 1);

    // PRIME period: low sides only
    measure();
    check("prime_hi_a", hi_cnt[0], 0);
    check("prime_hi_b", hi_cnt[1], 0);
    check("prime_hi_c", hi_cnt[2], 0);
    check("prime_mid_lo", int'(mid_lo), 7);

    // RUN sector 1, t1=400 t2=200: a=350 b1=550 c=650
    wait_sample(waited);
    sector = 3'd2;
    measure();
    check("s1_hi_a", hi_cnt[0], 1290);
    check("s1_hi_b", hi_cnt[1], 890);
    check("s1_hi_c", hi_cnt[2], 690);
    check("s1_lo_a", lo_cnt[0], 690);
    check("s1_lo_b", lo_cnt[1], 1090);
    check("s1_lo_c", lo_cnt[2], 1290);
    check("s1_sat", int'(mid_sat), 0);
    check("s1_fault", int'(mid_fault), 0);

    // RUN sector 2: B first, A on b2=450, C on c=650
    wait_sample(waited);
    t_1    = 15'd1500;
    t_2    = 15'd800;
    sector = 3'd1;
    measure();
    check("s2_hi_a", hi_cnt[0], 1090);
    check("s2_hi_b", hi_cnt[1], 1290);
    check("s2_hi_c", hi_cnt[2], 690);

    // Clamped period: t1=1500 t2=500 t0=0 -> a=0 b1=750 c=1000
    wait_sample(waited);
    t_1    = 15'd400;
    t_2    = 15'd200;
    sector = 3'd0;
    measure();
    check("clamp_sat", int'(mid_sat), 1);
    check("clamp_hi_a", hi_cnt[0], 1988);
    check("clamp_hi_b", hi_cnt[1], 490);
    check("clamp_hi_c", hi_cnt[2], 0);

    // Invalid sector period
    wait_sample(waited);
    sector = 3'd3;
    measure();
    check("fault_set", int'(mid_fault), 1);
    check("sat_cleared", int'(mid_sat), 0);
    check("fault_mid_hi", int'(mid_hi), 0);
    check("fault_mid_lo", int'(mid_lo), 7);

    // Sector 3: B on a=350, C on b1=550, A on c=650
    wait_sample(waited);
    measure();
    check("fault_cleared", int'(mid_fault), 0);
    check("s3_hi_a", hi_cnt[0], 690);
    check("s3_hi_b", hi_cnt[1], 1290);
    check("s3_hi_c", hi_cnt[2], 890);

    // Drop ENABLE at cnt=700
    wait_sample(waited);
    repeat (700) @(negedge clk);
    check("pre_drop_hi", int'(gate_hi), 7);
    enable = 1'b0;
    @(negedge clk);
    check("drop_hi", int'(gate_hi), 0);
    check("drop_lo", int'(gate_lo), 0);
    repeat (3) @(negedge clk);
    check("idle_lo", int'(gate_lo), 0);
    check("idle_sample", int'(sample), 0);
    enable = 1'b1;
    wait_sample(waited);
    check("reenable_latency", waited, 1);
    measure();
    check("reprime_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2], 0);
    check("reprime_mid_lo", int'(mid_lo), 7);
    wait_sample(waited);
    measure();
    check("resume_hi_b", hi_cnt[1], 1290);
    check("resume_hi_a", hi_cnt[0], 690);

    // Asynchronous reset mid-RUN
    wait_sample(waited);
    repeat (500) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hi", int'(gate_hi), 0);
    check("async_rst_lo", int'(gate_lo), 0);
    check("async_rst_sample", int'(sample), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_sample(waited);
    check("post_rst_latency", waited, 1);
    @(negedge clk);
    check("sample_one_cycle", int'(sample), 0);

    check("hi_lo_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
